// File: rtl/ram_bank_ring.sv
// N-bank frame buffer: the writer fills banks in ring order, and the reader streams
// committed banks in commit order at one word per cycle, with one bubble between banks.
module ram_bank_ring #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 256,
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int BANK_W     = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  wr_valid_i,
    input  logic                  wr_last_i,
    output logic                  wr_ready_o,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  rd_valid_o,
    output logic                  rd_last_o,
    input  logic                  rd_ready_i,
    output logic                  bank_ready_o,
    output logic                  overflow_o,
    output logic [BANK_W:0]       fill_level_o,
    output logic [ADDR_WIDTH:0]   wr_count_o
);

    localparam logic [BANK_W:0]     FULL      = (BANK_W+1)'(NUM_BANKS);
    localparam logic [BANK_W-1:0]   LAST_BANK = BANK_W'(NUM_BANKS-1);
    localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH+1)'(DEPTH-1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_STREAM = 2'd2
    } rd_state_e;

    logic [WIDTH-1:0]      mem_q [NUM_BANKS][DEPTH];
    logic [ADDR_WIDTH:0]   len_q [NUM_BANKS];

    logic [BANK_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   wr_cnt_q, wr_cnt_d;
    logic [BANK_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [BANK_W:0]       fill_q, fill_d;
    rd_state_e             state_q, state_d;
    logic [WIDTH-1:0]      rdata_q;
    logic                  bank_ready_q, overflow_q;

    logic wr_accept, wr_commit, rd_hs, rd_release;

    // ---------------- write side ----------------
    always_comb begin
        wr_ready_o = (fill_q < FULL);
        wr_accept  = wr_valid_i && wr_ready_o;
        wr_commit  = wr_accept && (wr_last_i || (wr_cnt_q == LAST_WORD));
        wr_ptr_d   = wr_ptr_q;
        wr_cnt_d   = wr_cnt_q;
        if (wr_commit) begin
            wr_ptr_d = (wr_ptr_q == LAST_BANK) ? '0 : wr_ptr_q + BANK_W'(1);
            wr_cnt_d = '0;
        end else if (wr_accept) begin
            wr_cnt_d = wr_cnt_q + (ADDR_WIDTH+1)'(1);
        end
    end

    // ---------------- read datapath ----------------
    always_comb begin
        rd_hs      = rd_valid_o && rd_ready_i;
        rd_release = rd_hs && rd_last_o;
        rd_ptr_d   = rd_ptr_q;
        if (rd_release)
            rd_ptr_d = (rd_ptr_q == LAST_BANK) ? '0 : rd_ptr_q + BANK_W'(1);
        // Lookahead address: the RAM already fetches the word that follows a handshake.
        rd_addr_d = '0;
        if (state_q == S_STREAM && !rd_release)
            rd_addr_d = rd_hs ? rd_addr_q + ADDR_WIDTH'(1) : rd_addr_q;
    end

    always_comb begin
        unique case ({wr_commit, rd_release})
            2'b10:   fill_d = fill_q + (BANK_W+1)'(1);
            2'b01:   fill_d = fill_q - (BANK_W+1)'(1);
            default: fill_d = fill_q;
        endcase
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (fill_q != '0) state_d = S_FETCH;
            S_FETCH:  state_d = S_STREAM;
            S_STREAM: if (rd_release) state_d = (fill_d != '0) ? S_FETCH : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_valid_o = (state_q == S_STREAM);
        rd_last_o  = (state_q == S_STREAM) &&
                     ({1'b0, rd_addr_q} == len_q[rd_ptr_q] - (ADDR_WIDTH+1)'(1));
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk_i) begin
        if (wr_accept)
            mem_q[wr_ptr_q][wr_cnt_q[ADDR_WIDTH-1:0]] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdata_q <= '0;
        else         rdata_q <= mem_q[rd_ptr_q][rd_addr_d];
    end

    // ---------------- control state ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            wr_cnt_q     <= '0;
            rd_ptr_q     <= '0;
            rd_addr_q    <= '0;
            fill_q       <= '0;
            bank_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) len_q[b] <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_addr_q    <= rd_addr_d;
            fill_q       <= fill_d;
            bank_ready_q <= wr_commit;
            overflow_q   <= wr_valid_i && !wr_ready_o;
            if (wr_commit) len_q[wr_ptr_q] <= wr_cnt_q + (ADDR_WIDTH+1)'(1);
        end
    end

    assign rd_data_o    = rdata_q;
    assign bank_ready_o = bank_ready_q;
    assign overflow_o   = overflow_q;
    assign fill_level_o = fill_q;
    assign wr_count_o   = wr_cnt_q;

endmodule
